// File: rtl/wb_byte_master_if.sv
// Byte-stream and Wishbone signal bundle for wb_byte_master.
// The master modport is the DUT's view; the slave modport is the host/bus side.
interface wb_byte_master_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic        o_wb_stb;
    logic        o_wb_cyc;
    logic        i_wb_ack;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_wb_dat, i_wb_ack,
        output o_rx_ready, o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_we,
        output o_wb_sel, o_wb_stb, o_wb_cyc
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_wb_dat, i_wb_ack,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_wb_adr, o_wb_dat, o_wb_we,
        input  o_wb_sel, o_wb_stb, o_wb_cyc
    );
endinterface

// File: rtl/wb_byte_master.sv
// Byte-command-driven single-cycle Wishbone initiator (write 0x57 / read 0x52 frames).
// Optional bus timeout enabled by defining WB_BYTE_MASTER_TIMEOUT_EN.
module wb_byte_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic        o_busy
);
  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RespAck = 8'h06;
  localparam logic [7:0] RespNak = 8'h15;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] resp_q, resp_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        rx_fire, tx_fire, ack, expired;

  assign rx_fire = i_rx_valid & o_rx_ready;
  assign tx_fire = o_tx_valid & i_tx_ready;
  assign ack     = i_wb_ack & cyc_q;

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  // Zero outside BUS so it is clear on the first BUS cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || state_q != StBus) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign expired = (state_q == StBus) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    resp_d  = resp_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          cnt_d = '0;
          if (i_rx_data == OpWrite || i_rx_data == OpRead) begin
            we_d    = (i_rx_data == OpWrite);
            state_d = StAddr;
          end else begin
            // Single-byte responses start at cnt=3 so RESP ends after one byte.
            resp_d  = {RespNak, 24'h0};
            cnt_d   = 2'd3;
            state_d = StResp;
          end
        end
      end
      StAddr: begin
        if (rx_fire) begin
          adr_d = {adr_q[23:0], i_rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = we_q ? StData : StBus;
            cyc_d   = ~we_q;
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          dat_d = {dat_q[23:0], i_rx_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StBus;
            cyc_d   = 1'b1;
          end
        end
      end
      StBus: begin
        if (ack) begin
          cyc_d   = 1'b0;
          state_d = StResp;
          resp_d  = we_q ? {RespAck, 24'h0} : i_wb_dat;
          cnt_d   = we_q ? 2'd3 : 2'd0;
        end else if (expired) begin
          cyc_d   = 1'b0;
          state_d = StResp;
          resp_d  = {RespNak, 24'h0};
          cnt_d   = 2'd3;
        end
      end
      StResp: begin
        if (tx_fire) begin
          resp_d = {resp_q[23:0], 8'h0};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      resp_q  <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      resp_q  <= resp_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
    end
  end

  assign o_rx_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StData);
  assign o_tx_valid = (state_q == StResp);
  assign o_tx_data  = resp_q[31:24];
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_we    = we_q;
  assign o_wb_sel   = {4{cyc_q}};
  assign o_wb_stb   = cyc_q;
  assign o_wb_cyc   = cyc_q;
  assign o_busy     = (state_q != StIdle);
endmodule

// File: tb/tb_wb_byte_master.sv
// Self-checking bench for wb_byte_master: frame table plus reset/backpressure/timeout sequences.
module tb_wb_byte_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  wb_byte_master_if bus ();

  always #5 clk = ~clk;

  wb_byte_master #(
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_data  (bus.i_rx_data),
    .i_rx_valid (bus.i_rx_valid),
    .o_rx_ready (bus.o_rx_ready),
    .o_tx_data  (bus.o_tx_data),
    .o_tx_valid (bus.o_tx_valid),
    .i_tx_ready (bus.i_tx_ready),
    .o_wb_adr   (bus.o_wb_adr),
    .o_wb_dat   (bus.o_wb_dat),
    .i_wb_dat   (bus.i_wb_dat),
    .o_wb_we    (bus.o_wb_we),
    .o_wb_sel   (bus.o_wb_sel),
    .o_wb_stb   (bus.o_wb_stb),
    .o_wb_cyc   (bus.o_wb_cyc),
    .i_wb_ack   (bus.i_wb_ack),
    .o_busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  // Slave model: ack once stb has been high for ack_delay prior cycles.
  int unsigned ack_delay  = 0;
  logic        ack_en     = 1'b1;
  int unsigned stb_cnt    = 0;
  logic [31:0] slave_rdat = '0;

  always @(posedge clk) stb_cnt <= bus.o_wb_stb ? stb_cnt + 1 : 0;
  assign bus.i_wb_ack = bus.o_wb_stb && ack_en && (stb_cnt >= ack_delay);
  assign bus.i_wb_dat = slave_rdat;

  typedef struct packed {logic [31:0] adr; logic [31:0] dat; logic we;} bus_t;
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor samples on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_extra: got byte %h expected none", bus.o_tx_data);
        end else begin
          check("tx_byte", {24'h0, bus.o_tx_data}, {24'h0, exp_tx.pop_front()});
        end
      end
      if (bus.o_wb_cyc && bus.o_wb_stb && bus.i_wb_ack) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_extra: got adr %h expected no cycle", bus.o_wb_adr);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          check("bus_adr", bus.o_wb_adr, e.adr);
          check("bus_we", {31'h0, bus.o_wb_we}, {31'h0, e.we});
          check("bus_sel", {28'h0, bus.o_wb_sel}, 32'hF);
          if (e.we) check("bus_dat", bus.o_wb_dat, e.dat);
        end
      end
      if (bus.o_wb_cyc || bus.o_tx_valid)
        check("rx_ready_low", {31'h0, bus.o_rx_ready}, 32'h0);
      check("stb_eq_cyc", {31'h0, bus.o_wb_stb}, {31'h0, bus.o_wb_cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    n = 0;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.o_rx_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL rx_accept: byte %h not accepted within 500 cycles", b);
        break;
      end
    end
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] adr,
                            input logic [31:0] dat, input int unsigned gap);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int i = 3; i >= 0; i--) begin
        repeat (gap) tick();
        send_byte(adr[8*i +: 8]);
      end
    end
    if (op == 8'h57) begin
      for (int i = 3; i >= 0; i--) begin
        repeat (gap) tick();
        send_byte(dat[8*i +: 8]);
      end
    end
  endtask

  task automatic wait_idle(output int stb_cyc);
    int n;
    n = 0;
    stb_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.o_wb_stb) stb_cyc++;
      if (!busy) break;
      n++;
      if (n > 2000) begin
        total++; bad++;
        $display("FAIL wait_idle: busy still %b after 2000 cycles, required 0", busy);
        break;
      end
    end
    tick();
  endtask

  task automatic expect_frame(input logic [7:0] op, input logic [31:0] adr,
                              input logic [31:0] dat);
    if (op == 8'h57) begin
      exp_bus.push_back('{adr: adr, dat: dat, we: 1'b1});
      exp_tx.push_back(8'h06);
    end else if (op == 8'h52) begin
      exp_bus.push_back('{adr: adr, dat: 32'h0, we: 1'b0});
      for (int i = 3; i >= 0; i--) exp_tx.push_back(dat[8*i +: 8]);
    end else begin
      exp_tx.push_back(8'h15);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] adr;
    logic [31:0] dat;   // write data, or slave read data for reads
    int unsigned dly;
    int unsigned gap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int stb_cyc;
    int exp_stb;
    logic [7:0] held;
    int n;

    vecs[0] = '{8'h57, 32'h10000004, 32'hDEADBEEF, 2, 0};
    vecs[1] = '{8'h52, 32'h00000008, 32'h12345678, 0, 0};
    vecs[2] = '{8'hA5, 32'h0, 32'h0, 0, 0};
    vecs[3] = '{8'h52, 32'h00000003, 32'hCAFEF00D, 1, 2};
    vecs[4] = '{8'h57, 32'hFFFFFFFC, 32'h00000001, 3, 1};
    vecs[5] = '{8'h00, 32'h0, 32'h0, 0, 0};

    bus.i_rx_data  = 8'h0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_cyc", {31'h0, bus.o_wb_cyc}, 32'h0);
    check("rst_sel", {28'h0, bus.o_wb_sel}, 32'h0);
    check("rst_we", {31'h0, bus.o_wb_we}, 32'h0);
    check("rst_adr", bus.o_wb_adr, 32'h0);
    check("rst_dat", bus.o_wb_dat, 32'h0);
    check("rst_tx_valid", {31'h0, bus.o_tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, bus.o_tx_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rx_ready", {31'h0, bus.o_rx_ready}, 32'h1);
    tick();

    foreach (vecs[i]) begin
      ack_delay  = vecs[i].dly;
      slave_rdat = vecs[i].dat;
      expect_frame(vecs[i].op, vecs[i].adr, vecs[i].dat);
      send_frame(vecs[i].op, vecs[i].adr, vecs[i].dat, vecs[i].gap);
      wait_idle(stb_cyc);
      exp_stb = (vecs[i].op == 8'h57 || vecs[i].op == 8'h52) ? int'(vecs[i].dly) + 1 : 0;
      check($sformatf("stb_cycles[%0d]", i), stb_cyc, exp_stb);
    end

    // TX backpressure: first read byte must hold while the sink stalls.
    ack_delay      = 0;
    slave_rdat     = 32'hA1B2C3D4;
    bus.i_tx_ready = 1'b0;
    expect_frame(8'h52, 32'h00000020, 32'hA1B2C3D4);
    send_frame(8'h52, 32'h00000020, 32'h0, 0);
    n = 0;
    while (!bus.o_tx_valid && n < 100) begin
      tick();
      n++;
    end
    held = bus.o_tx_data;
    check("bp_first_byte", {24'h0, held}, 32'hA1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", {31'h0, bus.o_tx_valid}, 32'h1);
      check("bp_data_held", {24'h0, bus.o_tx_data}, {24'h0, held});
      tick();
    end
    bus.i_tx_ready = 1'b1;
    wait_idle(stb_cyc);

    // Reset while a write cycle is stalled on the bus.
    ack_en = 1'b0;
    send_frame(8'h57, 32'h00000040, 32'h55AA55AA, 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.o_wb_cyc || n > 100) break;
      n++;
    end
    check("rst_mid_cyc_seen", {31'h0, bus.o_wb_cyc}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", {31'h0, bus.o_wb_cyc}, 32'h0);
    check("rst_mid_stb", {31'h0, bus.o_wb_stb}, 32'h0);
    check("rst_mid_tx_valid", {31'h0, bus.o_tx_valid}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    tick();
    ack_en     = 1'b1;
    ack_delay  = 1;
    slave_rdat = 32'h0BADF00D;
    expect_frame(8'h52, 32'h00000044, 32'h0BADF00D);
    send_frame(8'h52, 32'h00000044, 32'h0, 0);
    wait_idle(stb_cyc);
    check("post_rst_stb", stb_cyc, 2);

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    // No ack: strobe for the full timeout, then a single NAK.
    ack_en = 1'b0;
    expect_frame(8'hFF, 32'h0, 32'h0);
    send_frame(8'h52, 32'h00000050, 32'h0, 0);
    wait_idle(stb_cyc);
    check("tmo_stb", stb_cyc, 8);
    // Ack on the expiry cycle wins over the timeout.
    ack_en     = 1'b1;
    ack_delay  = 7;
    slave_rdat = 32'h87654321;
    expect_frame(8'h52, 32'h00000054, 32'h87654321);
    send_frame(8'h52, 32'h00000054, 32'h0, 0);
    wait_idle(stb_cyc);
    check("tmo_ack_stb", stb_cyc, 8);
`endif

    repeat (3) tick();
    check("tx_queue_drained", exp_tx.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
